morse_dec: RTL
==============

MORSE_DEC -- requirements
Module: morse_dec

Interface
REQ-001 Parameter DASH_MIN_CYC, default 4: minimum press length in cycles classified as dash; shorter presses are dots.
REQ-002 Parameter GAP_CYC, default 8: consecutive released cycles that terminate a letter.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 key_i  input  1  key level, 1 = pressed; already synchronous and debounced.
REQ-006 letter_o  output  3  decoded letter index, 0=A .. 7=H; valid only while valid_o=1.
REQ-007 valid_o  output  1  one-cycle pulse: letter_o holds a legal decode.
REQ-008 err_o  output  1  one-cycle pulse: the terminated symbol group matched no letter, or held more than 4 symbols.
REQ-009 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-010 Code format SHALL be code[3:0] plus len[2:0], with symbol i stored at code[i], first symbol at bit 0, 1=dash, 0=dot.
REQ-011 Letter table SHALL be A 0010/2, B 0001/4, C 0101/4, D 0001/3, E 0000/1, F 0100/4, G 0011/3, H 0000/4; unused code bits above len SHALL be 0.
REQ-012 FSM SHALL have the states IDLE, PRESS, GAP and EMIT.
REQ-013 IDLE: key_i=1 -> PRESS, press counter=1, code=0, len=0.
REQ-014 PRESS: key_i=1 increments press counter, saturating at DASH_MIN_CYC; key_i=0 stores the symbol (dash iff counter>=DASH_MIN_CYC) at code[len], increments len, sets gap counter=1, -> GAP.
REQ-015 A fifth symbol SHALL NOT be stored; it SHALL set an overflow flag and leave len at 4.
REQ-016 GAP: key_i=1 -> PRESS with press counter=1; key_i=0 increments the gap counter; reaching GAP_CYC -> EMIT.
REQ-017 If key_i=1 in the cycle the gap counter would reach GAP_CYC, the press SHALL win and the letter SHALL continue.
REQ-018 EMIT: exactly one cycle; either valid_o=1 with letter_o, or err_o=1 on overflow or a table miss; never both; -> IDLE.
REQ-019 Latency: valid_o/err_o SHALL assert on the cycle after the GAP_CYC-th consecutive released cycle.
REQ-020 A key press during EMIT SHALL be ignored; IDLE re-samples key_i on the next cycle.

Reset
REQ-021 While rst_i=1: state=IDLE, counters, code, len and overflow=0; valid_o=0, err_o=0, busy_o=0, letter_o=0.
REQ-022 Reset mid-letter SHALL discard partial symbols without any valid_o or err_o pulse.
REQ-023 If key_i=1 when reset releases, PRESS SHALL be entered on the first cycle after release.

Configuration
REQ-024 Macro MORSE_DEC_RAW_OUT_EN, when defined, SHALL add outputs code_o[3:0] and len_o[2:0], registered and valid with valid_o or err_o (len_o=4 on overflow).
REQ-025 Without MORSE_DEC_RAW_OUT_EN, those ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package morse_pkg SHALL hold the FSM state enum, code/len typedefs, letter index constants A..H and the code/len table.
REQ-027 Sub-module morse_lut SHALL be combinational, mapping code+len to letter plus a hit flag; morse_dec instantiates it once.

Verification (DASH_MIN_CYC=4, GAP_CYC=8)
REQ-028 Press 2, release 3, press 5, release 8 -> valid_o one cycle after the 8th low cycle, letter_o=0 (A).
REQ-029 Press 6, then three presses of 1 separated by releases of 2, then release 8 -> letter_o=1 (B).
REQ-030 Press 3, release 3, press 4, release 8 -> code 0010 len 2 -> letter_o=0 (A), confirming the 3/4 threshold.
REQ-031 Five dots separated by 2-cycle gaps, then release 8 -> err_o=1 for one cycle, valid_o=0.
REQ-032 Dash-dash-dash (O) -> err_o=1; key re-pressed exactly on the 8th low cycle -> no pulse, letter continues.
REQ-033 rst_i=1 for one cycle after two symbols -> no pulse, busy_o=0 next cycle; a following E decodes to letter_o=4.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and the letter code table for the Morse decoder.
// Codes are stored first-symbol-at-bit-0, 1 = dash, with unused upper bits held at zero.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    typedef logic [3:0] code_t;
    typedef logic [2:0] len_t;
    typedef logic [2:0] letter_t;

    localparam letter_t LTR_A = 3'd0;
    localparam letter_t LTR_B = 3'd1;
    localparam letter_t LTR_C = 3'd2;
    localparam letter_t LTR_D = 3'd3;
    localparam letter_t LTR_E = 3'd4;
    localparam letter_t LTR_F = 3'd5;
    localparam letter_t LTR_G = 3'd6;
    localparam letter_t LTR_H = 3'd7;

    localparam int   NUM_LETTERS = 8;
    localparam len_t MAX_LEN     = 3'd4;

    // Indexed by letter: A, B, C, D, E, F, G, H
    localparam code_t CODE_TBL [NUM_LETTERS] = '{
        4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000
    };
    localparam len_t LEN_TBL [NUM_LETTERS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4
    };

endpackage

// File: rtl/morse_lut.sv
// Combinational code+length to letter lookup; hit is low when no table entry matches.
module morse_lut
    import morse_pkg::*;
(
    input  code_t   code,
    input  len_t    len,
    output letter_t letter,
    output logic    hit
);

    // Scan the table; entries are unique so at most one can match
    always_comb begin
        letter = LTR_A;
        hit    = 1'b0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            letter = ((code == CODE_TBL[i]) && (len == LEN_TBL[i])) ? letter_t'(i) : letter;
            hit    = ((code == CODE_TBL[i]) && (len == LEN_TBL[i])) ? 1'b1 : hit;
        end
    end

endmodule

// File: rtl/morse_dec.sv
// Morse key decoder for letters A..H: classifies presses into dots/dashes and emits one pulse per letter.
// Optional macro MORSE_DEC_RAW_OUT_EN adds registered raw code_o/len_o outputs.
module morse_dec
    import morse_pkg::*;
#(
    parameter int DASH_MIN_CYC = 4,
    parameter int GAP_CYC      = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_i,
    output logic [2:0] letter_o,
    output logic       valid_o,
    output logic       err_o,
`ifdef MORSE_DEC_RAW_OUT_EN
    output logic [3:0] code_o,
    output logic [2:0] len_o,
`endif
    output logic       busy_o
);

    localparam int PW = $clog2(DASH_MIN_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [PW-1:0] DASH_MIN_V = PW'(DASH_MIN_CYC);
    localparam logic [GW-1:0] GAP_LAST_V = GW'(GAP_CYC - 1);

    state_t          state_r, state_nxt_s;
    logic [PW-1:0]   press_cnt_r, press_cnt_nxt_s;
    logic [GW-1:0]   gap_cnt_r, gap_cnt_nxt_s;
    code_t           code_r, code_nxt_s;
    len_t            len_r, len_nxt_s;
    logic            ovf_r, ovf_nxt_s;
    logic            emit_go_s;
    letter_t         lut_letter_s;
    logic            lut_hit_s;

    letter_t         letter_r;
    logic            valid_r;
    logic            err_r;
    logic            busy_r;

    morse_lut u_lut (
        .code   (code_r),
        .len    (len_r),
        .letter (lut_letter_s),
        .hit    (lut_hit_s)
    );

    // The GAP_CYC-th released cycle closes the letter; a press in that same cycle wins
    assign emit_go_s = (state_r == S_GAP) && !key_i && (gap_cnt_r >= GAP_LAST_V);

    // Next-state and datapath updates for the symbol-collecting FSM
    always_comb begin
        state_nxt_s     = state_r;
        press_cnt_nxt_s = press_cnt_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        code_nxt_s      = code_r;
        len_nxt_s       = len_r;
        ovf_nxt_s       = ovf_r;
        case (state_r)
            S_IDLE: begin
                if (key_i) begin
                    state_nxt_s     = S_PRESS;
                    press_cnt_nxt_s = PW'(1'b1);
                    gap_cnt_nxt_s   = '0;
                    code_nxt_s      = 4'b0000;
                    len_nxt_s       = 3'd0;
                    ovf_nxt_s       = 1'b0;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PRESS: begin
                if (key_i) begin
                    press_cnt_nxt_s = (press_cnt_r < DASH_MIN_V) ? press_cnt_r + 1'b1 : press_cnt_r;
                end else begin
                    if (len_r == MAX_LEN) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        code_nxt_s[len_r[1:0]] = (press_cnt_r >= DASH_MIN_V);
                        len_nxt_s              = len_r + 3'd1;
                    end
                    gap_cnt_nxt_s = GW'(1'b1);
                    state_nxt_s   = S_GAP;
                end
            end
            S_GAP: begin
                if (key_i) begin
                    state_nxt_s     = S_PRESS;
                    press_cnt_nxt_s = PW'(1'b1);
                end else if (emit_go_s) begin
                    state_nxt_s = S_EMIT;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 1'b1;
                end
            end
            S_EMIT: begin
                state_nxt_s     = S_IDLE;
                press_cnt_nxt_s = '0;
                gap_cnt_nxt_s   = '0;
                code_nxt_s      = 4'b0000;
                len_nxt_s       = 3'd0;
                ovf_nxt_s       = 1'b0;
            end
            default: begin
                state_nxt_s     = S_IDLE;
                press_cnt_nxt_s = '0;
                gap_cnt_nxt_s   = '0;
                code_nxt_s      = 4'b0000;
                len_nxt_s       = 3'd0;
                ovf_nxt_s       = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; outputs are loaded as EMIT is entered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            press_cnt_r <= '0;
            gap_cnt_r   <= '0;
            code_r      <= 4'b0000;
            len_r       <= 3'd0;
            ovf_r       <= 1'b0;
            letter_r    <= 3'd0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            press_cnt_r <= press_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            code_r      <= code_nxt_s;
            len_r       <= len_nxt_s;
            ovf_r       <= ovf_nxt_s;
            valid_r     <= emit_go_s && !ovf_r && lut_hit_s;
            err_r       <= emit_go_s && (ovf_r || !lut_hit_s);
            letter_r    <= (emit_go_s && !ovf_r && lut_hit_s) ? lut_letter_s : 3'd0;
            busy_r      <= (state_nxt_s != S_IDLE);
        end
    end

    assign letter_o = letter_r;
    assign valid_o  = valid_r;
    assign err_o    = err_r;
    assign busy_o   = busy_r;

`ifdef MORSE_DEC_RAW_OUT_EN
    code_t code_out_r;
    len_t  len_out_r;

    // Raw symbol group captured alongside every valid/err pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            code_out_r <= 4'b0000;
            len_out_r  <= 3'd0;
        end else if (emit_go_s) begin
            code_out_r <= code_r;
            len_out_r  <= len_r;
        end else begin
            code_out_r <= code_out_r;
            len_out_r  <= len_out_r;
        end
    end

    assign code_o = code_out_r;
    assign len_o  = len_out_r;
`endif

endmodule
